// File: rtl/add_arbiter_if.sv
// add_arbiter_if: request/response bundle between two requesters, a consumer and add_arbiter
// Ports (signals):
//   req0_valid/req0_ready/req0_a/req0_b/req0_sub  requester 0 operation handshake and operands
//   req1_valid/req1_ready/req1_a/req1_b/req1_sub  requester 1 operation handshake and operands
//   rsp_valid/rsp_ready                            response handshake
//   rsp_id/rsp_z/rsp_cout/rsp_ovf                  response tag, sum/difference, carry, signed overflow
// Modports: slave = arbiter side, master = requester/consumer side.
interface add_arbiter_if #(parameter int W = 32);
   logic req0_valid, req0_ready, req0_sub;
   logic req1_valid, req1_ready, req1_sub;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b, rsp_z;
   logic rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sub,
      input  req1_valid, req1_a, req1_b, req1_sub, rsp_ready,
      output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_z, rsp_cout, rsp_ovf
   );
   modport master (
      output req0_valid, req0_a, req0_b, req0_sub,
      output req1_valid, req1_a, req1_b, req1_sub, rsp_ready,
      input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_z, rsp_cout, rsp_ovf
   );
endinterface

// File: rtl/add_arbiter.sv
// add_arbiter: two-requester arbiter and sequencer for one shared 32-bit adder, one op in flight
// Ports:
//   clk    clock, all state on rising edge
//   reset  asynchronous active-high reset
//   bus    add_arbiter_if.slave: request channels 0/1 in, tagged result channel out
// Parameters:
//   W   datapath width, 32 only
//   RR  1 = round-robin grant, 0 = fixed priority to requester 0
module add_arbiter #(
   parameter int W = 32,
   parameter bit RR = 1'b1
) (
   input logic clk,
   input logic reset,
   add_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
   state_t state, state_n;
   logic last, g0, g1, acc, sub_q, id_q, cout;
   logic [W-1:0] a_q, b_q, b_eff, z;
   // requester 0 wins unless requester 1 is alone, or round-robin says it was served last
   assign g0 = bus.req0_valid && (!bus.req1_valid || !RR || last);
   assign g1 = bus.req1_valid && !g0;
   assign bus.req0_ready = state == IDLE && g0 && !reset;
   assign bus.req1_ready = state == IDLE && g1 && !reset;
   assign acc = bus.req0_ready || bus.req1_ready;
   assign bus.rsp_valid = state == RESP;
   // subtract as a + ~b + 1, so carry-out doubles as "no borrow"
   assign b_eff = sub_q ? ~b_q : b_q;
   assign {cout, z} = {1'b0, a_q} + {1'b0, b_eff} + {{W{1'b0}}, sub_q};
   always_comb begin
      state_n = state;
      case (state)
         IDLE: state_n = acc ? CALC : IDLE;
         CALC: state_n = RESP;
         RESP: state_n = bus.rsp_ready ? IDLE : RESP;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else state <= state_n;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last <= 1'b1;
         a_q <= '0;
         b_q <= '0;
         sub_q <= 1'b0;
         id_q <= 1'b0;
         bus.rsp_id <= 1'b0;
         bus.rsp_z <= '0;
         bus.rsp_cout <= 1'b0;
         bus.rsp_ovf <= 1'b0;
      end else begin
         if (acc) begin
            a_q <= g0 ? bus.req0_a : bus.req1_a;
            b_q <= g0 ? bus.req0_b : bus.req1_b;
            sub_q <= g0 ? bus.req0_sub : bus.req1_sub;
            id_q <= g1;
            last <= g1;
         end
         if (state == CALC) begin
            bus.rsp_z <= z;
            bus.rsp_cout <= cout;
            bus.rsp_ovf <= (a_q[W-1] == b_eff[W-1]) && (z[W-1] != a_q[W-1]);
            bus.rsp_id <= id_q;
         end
      end
   end
endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed and randomized check of add_arbiter against an arithmetic reference model
module tb_add_arbiter;
   logic clk = 1'b0;
   logic reset;
   int vectors = 0;
   int miscompares = 0;
   bit exp_last;
   logic [31:0] edges [5] = '{32'h0, 32'h1, 32'h7fffffff, 32'h80000000, 32'hffffffff};
   always #5 clk = ~clk;
   add_arbiter_if #(.W(32)) u0 ();
   add_arbiter_if #(.W(32)) u1 ();
   add_arbiter #(.W(32), .RR(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(u0.slave));
   add_arbiter #(.W(32), .RR(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(u1.slave));
   // {ovf, cout, z} from wide signed/unsigned arithmetic
   function automatic logic [33:0] model(input logic [31:0] a, b, input logic sub);
      longint sr, ur;
      logic c, v;
      sr = sub ? longint'($signed(a)) - longint'($signed(b)) : longint'($signed(a)) + longint'($signed(b));
      ur = sub ? longint'({32'h0, a}) - longint'({32'h0, b}) : longint'({32'h0, a}) + longint'({32'h0, b});
      c = sub ? (a >= b) : ur[32];
      v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      return {v, c, ur[31:0]};
   endfunction
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input bit id, input logic v, input logic [31:0] a, b, input logic s);
      if (id) begin
         u0.req1_valid = v; u0.req1_a = a; u0.req1_b = b; u0.req1_sub = s;
      end else begin
         u0.req0_valid = v; u0.req0_a = a; u0.req0_b = b; u0.req0_sub = s;
      end
   endtask
   task automatic op(input bit id, input logic [31:0] a, b, input logic s, input int hold);
      logic [33:0] e;
      e = model(a, b, s);
      u0.rsp_ready = (hold == 0);
      drive(id, 1'b1, a, b, s);
      #1;
      chk("grant_ready", id ? u0.req1_ready : u0.req0_ready, 1);
      chk("other_ready", id ? u0.req0_ready : u0.req1_ready, 0);
      step;
      drive(id, 1'b0, $urandom, $urandom, 1'b0);
      exp_last = id;
      chk("calc_valid", u0.rsp_valid, 0);
      step;
      chk("rsp_valid", u0.rsp_valid, 1);
      chk("rsp_id", u0.rsp_id, id);
      chk("rsp_z", u0.rsp_z, e[31:0]);
      chk("rsp_cout", u0.rsp_cout, e[32]);
      chk("rsp_ovf", u0.rsp_ovf, e[33]);
      for (int i = 0; i < hold; i++) begin
         step;
         u0.req0_valid = 1'b1;
         u0.req1_valid = 1'b1;
         #1;
         chk("hold_valid", u0.rsp_valid, 1);
         chk("hold_rsp", {u0.rsp_ovf, u0.rsp_cout, u0.rsp_id, u0.rsp_z}, {e[33], e[32], id, e[31:0]});
         chk("hold_ready", {u0.req0_ready, u0.req1_ready}, 0);
      end
      u0.req0_valid = 1'b0;
      u0.req1_valid = 1'b0;
      u0.rsp_ready = 1'b1;
      step;
      chk("consumed", u0.rsp_valid, 0);
   endtask
   initial begin
      logic [31:0] a0, b0, a1, b1, ra, rb;
      logic [33:0] e;
      bit g, rid;
      reset = 1'b1;
      u0.req0_valid = 1'b1; u0.req0_a = '0; u0.req0_b = '0; u0.req0_sub = 1'b0;
      u0.req1_valid = 1'b0; u0.req1_a = '0; u0.req1_b = '0; u0.req1_sub = 1'b0;
      u0.rsp_ready = 1'b0;
      u1.req0_valid = 1'b0; u1.req0_a = '0; u1.req0_b = '0; u1.req0_sub = 1'b0;
      u1.req1_valid = 1'b0; u1.req1_a = '0; u1.req1_b = '0; u1.req1_sub = 1'b0;
      u1.rsp_ready = 1'b0;
      step;
      step;
      chk("reset_ready", {u0.req0_ready, u0.req1_ready}, 0);
      chk("reset_rsp", {u0.rsp_valid, u0.rsp_id, u0.rsp_cout, u0.rsp_ovf, u0.rsp_z}, 0);
      u0.req0_valid = 1'b0;
      reset = 1'b0;
      exp_last = 1'b1;
      step;
      op(0, 32'd5, 32'd7, 1'b0, 0);
      op(1, 32'd5, 32'd3, 1'b1, 0);
      op(1, 32'd3, 32'd5, 1'b1, 0);
      op(0, 32'h7fffffff, 32'd1, 1'b0, 0);
      op(0, 32'hffffffff, 32'd1, 1'b0, 0);
      op(1, 32'h80000000, 32'd1, 1'b1, 0);
      op(0, 32'h12345678, 32'h9abcdef0, 1'b1, 5);
      // round-robin contention, one result per three cycles
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      u0.rsp_ready = 1'b1;
      drive(0, 1'b1, a0, b0, 1'b0);
      drive(1, 1'b1, a1, b1, 1'b1);
      for (int n = 0; n < 6; n++) begin
         g = !exp_last;
         #1;
         chk("rr_ready", {u0.req1_ready, u0.req0_ready}, g ? 2'b10 : 2'b01);
         step;
         exp_last = g;
         step;
         e = g ? model(a1, b1, 1'b1) : model(a0, b0, 1'b0);
         chk("rr_valid", u0.rsp_valid, 1);
         chk("rr_id", u0.rsp_id, g);
         chk("rr_z", u0.rsp_z, e[31:0]);
         step;
      end
      u0.req0_valid = 1'b0;
      u0.req1_valid = 1'b0;
      // fixed priority instance
      u1.rsp_ready = 1'b1;
      u1.req0_valid = 1'b1; u1.req0_a = 32'd10; u1.req0_b = 32'd4; u1.req0_sub = 1'b1;
      u1.req1_valid = 1'b1; u1.req1_a = 32'd1; u1.req1_b = 32'd1; u1.req1_sub = 1'b0;
      for (int n = 0; n < 4; n++) begin
         #1;
         chk("fp_ready", {u1.req1_ready, u1.req0_ready}, 2'b01);
         step;
         step;
         chk("fp_id", {u1.rsp_valid, u1.rsp_id, u1.rsp_z}, {1'b1, 1'b0, 32'd6});
         step;
      end
      u1.req0_valid = 1'b0;
      u1.req1_valid = 1'b0;
      step;
      // reset while an op from requester 0 is in CALC
      u0.rsp_ready = 1'b1;
      op(1, 32'd1, 32'd2, 1'b0, 0);
      drive(0, 1'b1, 32'd100, 32'd1, 1'b0);
      step;
      drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
      reset = 1'b1;
      #1;
      chk("mid_reset_rsp", {u0.rsp_valid, u0.rsp_z}, 0);
      u0.req0_valid = 1'b1;
      u0.req1_valid = 1'b1;
      #1;
      chk("mid_reset_ready", {u0.req0_ready, u0.req1_ready}, 0);
      step;
      reset = 1'b0;
      exp_last = 1'b1;
      #1;
      chk("post_reset_valid", u0.rsp_valid, 0);
      chk("post_reset_grant", {u0.req1_ready, u0.req0_ready}, 2'b01);
      u0.req1_valid = 1'b0;
      op(0, 32'd40, 32'd2, 1'b0, 0);
      // random ops
      for (int n = 0; n < 1000; n++) begin
         rid = 1'($urandom_range(0, 1));
         ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
         op(rid, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
